// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_rdy flags the byte completing a word.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_rdy
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (byte_en) begin
      word[byte_cnt*BYTE_W +: BYTE_W] <= byte_data;
      byte_cnt                        <= byte_cnt + 2'd1;
    end
  end

  // Combinational so the FSM can leave DATA on the same edge the 4th byte lands.
  assign word_rdy = byte_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Host byte stream -> instruction memory writer; holds the core in reset while loading.
// Optional trailing XOR checksum byte enabled by defining INSTR_LOADER_CSUM_EN.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH         = 64,
  parameter bit          HOLD_ON_RESET = 1'b1,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              core_rst_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned NW = AW + 1;

  loader_state_t state, state_nxt;
  logic [NW-1:0] n_words;
  logic          accept;
  logic          pack_en;
  logic          pack_clr;
  logic          word_rdy;
  logic          last_word;
  logic          len_too_big;
`ifdef INSTR_LOADER_CSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  assign byte_ready  = (state == LEN) || (state == DATA) || (state == CSUM);
  assign accept      = byte_valid && byte_ready;
  assign pack_en     = accept && (state == DATA);
  assign pack_clr    = (state == IDLE) && load_start;
  assign wr_en       = (state == WRITE);
  assign last_word   = ({1'b0, wr_addr} == (n_words - NW'(1)));
  assign len_too_big = ({24'b0, byte_data} > DEPTH);

  byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pack_clr),
    .byte_en   (pack_en),
    .byte_data (byte_data),
    .word      (wr_data),
    .word_rdy  (word_rdy)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load_start) state_nxt = LEN;
      LEN: begin
        if (accept) begin
          if (byte_data == '0)  state_nxt = DONE;
          else if (len_too_big) state_nxt = ERR;
          else                  state_nxt = DATA;
        end
      end
      DATA:  if (word_rdy) state_nxt = WRITE;
      WRITE: begin
`ifdef INSTR_LOADER_CSUM_EN
        state_nxt = last_word ? CSUM : DATA;
`else
        state_nxt = last_word ? DONE : DATA;
`endif
      end
`ifdef INSTR_LOADER_CSUM_EN
      CSUM:  if (accept) state_nxt = (byte_data == csum) ? DONE : ERR;
`endif
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from state_nxt so done/release appear in the DONE cycle itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      n_words    <= '0;
      wr_addr    <= '0;
      core_rst_n <= !HOLD_ON_RESET;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      load_done <= (state_nxt == DONE);
      if (pack_clr) begin
        core_rst_n <= 1'b0;
        load_busy  <= 1'b1;
        load_err   <= 1'b0;
        wr_addr    <= '0;
`ifdef INSTR_LOADER_CSUM_EN
        csum       <= '0;
`endif
      end
      if ((state == LEN) && accept) n_words <= NW'(byte_data);
      // wr_addr doubles as the word counter and parks on N-1 after the last write.
      if ((state == WRITE) && !last_word) wr_addr <= wr_addr + AW'(1);
`ifdef INSTR_LOADER_CSUM_EN
      if (pack_en) csum <= csum ^ byte_data;
`endif
      if (state_nxt == DONE) begin
        core_rst_n <= 1'b1;
        load_busy  <= 1'b0;
      end
      if (state_nxt == ERR) begin
        load_err  <= 1'b1;
        load_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a stream-level reference model.
module tb_instr_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;
`ifdef INSTR_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          core_rst_n;
  logic          load_busy;
  logic          load_done;
  logic          load_err;

  instr_loader #(.DEPTH(DEPTH), .HOLD_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_rst_n (core_rst_n),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  stream[$];
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          ready_hits = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(wr_data);
      got_cyc.push_back(cyc);
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (byte_ready) ready_hits++;
  end

  function automatic logic [7:0] xor_data(input int n);
    logic [7:0] x = '0;
    for (int i = 1; i <= 4 * n; i++) x ^= stream[i];
    return x;
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("busy_after_start", 32'(load_busy), 32'd1);
    check("core_held", 32'(core_rst_n), 32'd0);
    check("err_cleared", 32'(load_err), 32'd0);
  endtask

  // Offers the first nbytes of the stream, with random idle gaps, honouring byte_ready.
  task automatic drive(input int nbytes, input int gap_pct);
    for (int i = 0; i < nbytes; i++) begin
      int waited = 0;
      bit took = 1'b0;
      for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = stream[i];
      while (!took) begin
        if (byte_ready) begin
          took = 1'b1;
          acc_cyc.push_back(cyc);
        end
        @(negedge clk);
        waited++;
        if (!took && waited > 100) begin
          check("ready_timeout", 32'd0, 32'd1);
          byte_valid = 1'b0;
          return;
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_and_check(input int gap_pct);
    int n, exp_nw;
    bit exp_err;
    got_addr.delete(); got_data.delete(); got_cyc.delete(); acc_cyc.delete();
    done_cnt = 0;
    start_load();
    drive(stream.size(), gap_pct);
    for (int k = 0; k < 20 && done_cnt == 0 && !load_err; k++) @(negedge clk);
    repeat (3) @(negedge clk);

    n       = int'(stream[0]);
    exp_err = (n > int'(DEPTH));
    exp_nw  = exp_err ? 0 : n;
    if (CSUM && !exp_err && n != 0) exp_err = (stream[4 * n + 1] != xor_data(n));

    check("wr_count", 32'(got_addr.size()), 32'(exp_nw));
    for (int i = 0; i < exp_nw && i < got_addr.size(); i++) begin
      check("wr_addr", 32'(got_addr[i]), 32'(i));
      check("wr_data", got_data[i],
            {stream[4*i+4], stream[4*i+3], stream[4*i+2], stream[4*i+1]});
      if (acc_cyc.size() > 4 * i + 4)
        check("wr_latency", 32'(got_cyc[i]), 32'(acc_cyc[4*i+4] + 1));
    end
    check("done_pulses", 32'(done_cnt), exp_err ? 32'd0 : 32'd1);
    check("load_err", 32'(load_err), 32'(exp_err));
    check("core_rst_n", 32'(core_rst_n), exp_err ? 32'd0 : 32'd1);
    check("busy_end", 32'(load_busy), 32'd0);
    if (!exp_err && acc_cyc.size() == stream.size())
      check("done_latency", 32'(done_cyc),
            32'(acc_cyc[$] + ((n == 0 || CSUM) ? 1 : 2)));
  endtask

  task automatic base_stream();
    stream = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM) stream.push_back(xor_data(2));
  endtask

  task automatic rand_stream(input int n, input bit bad_csum);
    stream.delete();
    stream.push_back(8'(n));
    if (n > int'(DEPTH) || n == 0) return;
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    if (CSUM) stream.push_back(bad_csum ? ~xor_data(n) : xor_data(n));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, then idle with a byte offered: nothing may be taken or written.
    repeat (3) @(negedge clk);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    reset_n = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    got_addr.delete();
    ready_hits = 0;
    done_cnt = 0;
    repeat (100) @(negedge clk);
    byte_valid = 1'b0;
    check("idle_wr_count", 32'(got_addr.size()), 32'd0);
    check("idle_ready_hits", 32'(ready_hits), 32'd0);
    check("idle_core_rst_n", 32'(core_rst_n), 32'd0);
    check("idle_busy", 32'(load_busy), 32'd0);
    check("idle_err", 32'(load_err), 32'd0);
    check("idle_done", 32'(done_cnt), 32'd0);

    // Reference stream, back-to-back and then with gaps/stalls.
    base_stream();
    run_and_check(0);
    base_stream();
    run_and_check(50);

    // Length beyond depth, then a clean reload clears the sticky error.
    stream = '{8'h41};
    run_and_check(0);
    base_stream();
    run_and_check(20);

`ifdef INSTR_LOADER_CSUM_EN
    base_stream();
    run_and_check(0);
    base_stream();
    stream[$] = ~stream[$];
    run_and_check(10);
`endif

    // Reset mid-word, then a fresh single-word load must see no stale bytes.
    base_stream();
    start_load();
    drive(7, 0);
    reset_n = 1'b0;
    #1;
    check("abort_core_rst_n", 32'(core_rst_n), 32'd0);
    check("abort_busy", 32'(load_busy), 32'd0);
    check("abort_ready", 32'(byte_ready), 32'd0);
    check("abort_wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    stream = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CSUM) stream.push_back(xor_data(1));
    run_and_check(30);
    if (got_data.size() > 0) check("deadbeef", got_data[0], 32'hDEADBEEF);

    // Boundaries: zero words, full depth, one past depth.
    rand_stream(0, 1'b0);
    run_and_check(0);
    rand_stream(int'(DEPTH), 1'b0);
    run_and_check(25);
    rand_stream(int'(DEPTH) + 1, 1'b0);
    run_and_check(0);

    for (int r = 0; r < 8; r++) begin
      rand_stream(int'($urandom_range(1, 9)), ($urandom_range(2) == 0));
      run_and_check(int'($urandom_range(60)));
    end
    rand_stream(int'($urandom_range(DEPTH + 1, 255)), 1'b0);
    run_and_check(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
